// File: rtl/ofdm_pkg.sv
// Shared OFDM receive-path definitions: symbol-framing states and default geometry.
package ofdm_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CP   = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam int N_FFT_DEF  = 64;
    localparam int CP_LEN_DEF = 16;
    localparam int W_DEF      = 16;
endpackage

// File: rtl/sat_negate.sv
// Combinational saturating two's-complement negation of one signed sample.
module sat_negate #(
    parameter int W = 16
) (
    input  logic signed [W-1:0] a,
    output logic signed [W-1:0] y
);
    localparam logic signed [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [W-1:0] MOST_POS = {1'b0, {(W-1){1'b1}}};

    // The most negative value has no positive counterpart, so it clips.
    function automatic logic signed [W-1:0] sat_neg(input logic signed [W-1:0] v);
        if (v == MOST_NEG)
            return MOST_POS;
        else
            return -v;
    endfunction

    assign y = sat_neg(a);
endmodule

// File: rtl/cp_strip_derot.sv
// Strips the cyclic prefix from each received OFDM symbol and multiplies the useful
// samples by (-1)^k, moving the spectrum by N_FFT/2 bins ahead of the FFT.
module cp_strip_derot
    import ofdm_pkg::*;
#(
    parameter int N_FFT  = N_FFT_DEF,
    parameter int CP_LEN = CP_LEN_DEF,
    parameter int W      = W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                in_sop,
    input  logic signed [W-1:0] in_i,
    input  logic signed [W-1:0] in_q,
    output logic signed [W-1:0] out_i,
    output logic signed [W-1:0] out_q,
    output logic                out_valid,
    output logic                out_sop,
    output logic                out_eop,
    output logic                sync_err
);
    localparam int CW = $clog2(N_FFT);
    localparam logic [CW-1:0] CP_LAST = CW'(CP_LEN - 1);
    localparam logic [CW-1:0] K_LAST  = CW'(N_FFT - 1);

    state_t              state;
    logic [CW-1:0]       cnt;
    logic signed [W-1:0] neg_i;
    logic signed [W-1:0] neg_q;

    sat_negate #(.W(W)) u_neg_i (.a(in_i), .y(neg_i));
    sat_negate #(.W(W)) u_neg_q (.a(in_q), .y(neg_q));

    // Single registered stage: framing state, counter and the output sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            out_i     <= '0;
            out_q     <= '0;
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            sync_err  <= 1'b0;
            if (en) begin
                // A start marker always wins and resynchronises to CP index 0.
                if (in_sop) begin
                    sync_err <= (state != IDLE);
                    if (CP_LEN == 1) begin
                        state <= DATA;
                        cnt   <= '0;
                    end else begin
                        state <= CP;
                        cnt   <= CW'(1);
                    end
                end else begin
                    case (state)
                        IDLE: begin
                            cnt <= '0;
                        end
                        CP: begin
                            if (cnt == CP_LAST) begin
                                state <= DATA;
                                cnt   <= '0;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                        DATA: begin
                            out_valid <= 1'b1;
                            out_i     <= cnt[0] ? neg_i : in_i;
                            out_q     <= cnt[0] ? neg_q : in_q;
                            out_sop   <= (cnt == '0);
                            out_eop   <= (cnt == K_LAST);
                            if (cnt == K_LAST) begin
                                state <= IDLE;
                                cnt   <= '0;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                        default: begin
                            state <= IDLE;
                            cnt   <= '0;
                        end
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_cp_strip_derot.sv
// Directed bench for cp_strip_derot at N_FFT=64, CP_LEN=16, W=16.
module tb_cp_strip_derot;
    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               en = 1'b0;
    logic               in_sop = 1'b0;
    logic signed [15:0] in_i = '0;
    logic signed [15:0] in_q = '0;
    logic signed [15:0] out_i;
    logic signed [15:0] out_q;
    logic               out_valid;
    logic               out_sop;
    logic               out_eop;
    logic               sync_err;

    int total = 0;
    int bad   = 0;

    cp_strip_derot #(.N_FFT(64), .CP_LEN(16), .W(16)) dut (
        .clk(clk), .rst(rst), .en(en), .in_sop(in_sop),
        .in_i(in_i), .in_q(in_q),
        .out_i(out_i), .out_q(out_q), .out_valid(out_valid),
        .out_sop(out_sop), .out_eop(out_eop), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // One input sample presented for one clock; outputs are readable on return.
    task automatic step(input logic e, input logic s, input int i, input int q);
        en = e;
        in_sop = s;
        in_i = 16'(i);
        in_q = 16'(q);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        en = 1'b0;
        in_sop = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        en = 1'b1;
        in_sop = 1'b1;
        in_i = 16'sd1234;
        in_q = -16'sd77;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
        total++; if (out_i !== 16'sd0 || out_q !== 16'sd0) begin bad++; $display("FAIL reset_data got=%0d/%0d want=0/0", out_i, out_q); end
        total++; if ({out_sop, out_eop, sync_err} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {out_sop, out_eop, sync_err}); end
        rst = 1'b0;
        for (int n = 0; n < 20; n++) begin
            step(1'b1, 1'b0, n, n);
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL idle_discard n=%0d got=%b want=0", n, out_valid); end
        end
    endtask

    task automatic test_basic();
        logic signed [15:0] e_i;
        logic signed [15:0] e_q;
        int k;
        apply_reset();
        for (int n = 0; n < 80; n++) begin
            step(1'b1, n == 0, n, 1000 - n);
            if (n < 16) begin
                total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_cp_valid n=%0d got=%b want=0", n, out_valid); end
            end else begin
                k = n - 16;
                e_i = (k % 2 == 1) ? 16'(-n) : 16'(n);
                e_q = (k % 2 == 1) ? 16'(n - 1000) : 16'(1000 - n);
                total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid k=%0d got=%b want=1", k, out_valid); end
                total++; if (out_i !== e_i || out_q !== e_q) begin bad++; $display("FAIL basic_data k=%0d got=%0d/%0d want=%0d/%0d", k, out_i, out_q, e_i, e_q); end
                total++; if (out_sop !== (k == 0) || out_eop !== (k == 63)) begin bad++; $display("FAIL basic_sop_eop k=%0d got=%b%b", k, out_sop, out_eop); end
                total++; if (sync_err !== 1'b0) begin bad++; $display("FAIL basic_sync_err k=%0d got=1 want=0", k); end
            end
            if (n == 16) begin
                total++; if (out_i !== 16'sd16) begin bad++; $display("FAIL basic_first got=%0d want=16", out_i); end
            end
            if (n == 17) begin
                total++; if (out_i !== -16'sd17) begin bad++; $display("FAIL basic_second got=%0d want=-17", out_i); end
            end
            if (n == 79) begin
                total++; if (out_i !== -16'sd79) begin bad++; $display("FAIL basic_last got=%0d want=-79", out_i); end
            end
        end
        step(1'b1, 1'b0, 5, 5);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_after_end got=%b want=0", out_valid); end
        total++; if (out_i !== -16'sd79) begin bad++; $display("FAIL basic_hold got=%0d want=-79", out_i); end
    endtask

    task automatic test_saturation();
        apply_reset();
        step(1'b1, 1'b1, 0, 0);
        for (int n = 1; n < 16; n++) step(1'b1, 1'b0, 0, 0);
        step(1'b1, 1'b0, -32768, 32767);
        total++; if (out_i !== -16'sd32768 || out_q !== 16'sd32767) begin bad++; $display("FAIL sat_even got=%0d/%0d want=-32768/32767", out_i, out_q); end
        step(1'b1, 1'b0, -32768, 32767);
        total++; if (out_i !== 16'sd32767 || out_q !== -16'sd32767) begin bad++; $display("FAIL sat_odd got=%0d/%0d want=32767/-32767", out_i, out_q); end
        step(1'b1, 1'b0, -5, 7);
        total++; if (out_i !== -16'sd5 || out_q !== 16'sd7) begin bad++; $display("FAIL sat_k2 got=%0d/%0d want=-5/7", out_i, out_q); end
        step(1'b1, 1'b0, -5, 7);
        total++; if (out_i !== 16'sd5 || out_q !== -16'sd7) begin bad++; $display("FAIL sat_k3 got=%0d/%0d want=5/-7", out_i, out_q); end
    endtask

    task automatic test_stall();
        logic signed [15:0] e_i;
        logic signed [15:0] last_i;
        int k;
        apply_reset();
        last_i = 16'sd0;
        for (int n = 0; n < 80; n++) begin
            step(1'b1, n == 0, n, n);
            if (n >= 16) begin
                k = n - 16;
                e_i = (k % 2 == 1) ? 16'(-n) : 16'(n);
                last_i = e_i;
                total++; if (out_valid !== 1'b1 || out_i !== e_i || out_q !== e_i) begin bad++; $display("FAIL stall_data k=%0d got=%b %0d/%0d want=1 %0d", k, out_valid, out_i, out_q, e_i); end
                total++; if (out_sop !== (k == 0) || out_eop !== (k == 63)) begin bad++; $display("FAIL stall_sop_eop k=%0d got=%b%b", k, out_sop, out_eop); end
            end else begin
                total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_cp n=%0d got=%b want=0", n, out_valid); end
            end
            step(1'b0, 1'b1, 999, -999);
            total++; if (out_valid !== 1'b0 || sync_err !== 1'b0) begin bad++; $display("FAIL stall_gap n=%0d got=%b%b want=00", n, out_valid, sync_err); end
            total++; if (out_i !== last_i) begin bad++; $display("FAIL stall_hold n=%0d got=%0d want=%0d", n, out_i, last_i); end
        end
    endtask

    task automatic test_sync_err();
        int eops;
        int extra;
        apply_reset();
        eops = 0;
        for (int n = 0; n < 46; n++) begin
            step(1'b1, n == 0, n, n);
            if (out_eop === 1'b1) eops++;
        end
        total++; if (out_valid !== 1'b1 || out_i !== -16'sd45) begin bad++; $display("FAIL sync_pre got=%b %0d want=1 -45", out_valid, out_i); end
        step(1'b1, 1'b1, 46, 46);
        total++; if (sync_err !== 1'b1) begin bad++; $display("FAIL sync_pulse got=%b want=1", sync_err); end
        total++; if (out_valid !== 1'b0 || out_eop !== 1'b0) begin bad++; $display("FAIL sync_no_out got=%b%b want=00", out_valid, out_eop); end
        extra = 0;
        for (int n = 1; n < 16; n++) begin
            step(1'b1, 1'b0, 0, 0);
            if (out_valid !== 1'b0 || sync_err !== 1'b0) extra++;
            if (out_eop === 1'b1) eops++;
        end
        total++; if (extra != 0) begin bad++; $display("FAIL sync_cp_quiet got=%0d events want=0", extra); end
        total++; if (eops != 0) begin bad++; $display("FAIL sync_no_eop got=%0d want=0", eops); end
        step(1'b1, 1'b0, 500, -500);
        total++; if (out_valid !== 1'b1 || out_sop !== 1'b1 || out_i !== 16'sd500 || out_q !== -16'sd500) begin bad++; $display("FAIL sync_next_k0 got=%b%b %0d/%0d want=11 500/-500", out_valid, out_sop, out_i, out_q); end
        step(1'b1, 1'b0, 501, -501);
        total++; if (out_i !== -16'sd501 || out_q !== 16'sd501 || out_sop !== 1'b0) begin bad++; $display("FAIL sync_next_k1 got=%0d/%0d sop=%b want=-501/501 0", out_i, out_q, out_sop); end
    endtask

    task automatic test_sop_at_last();
        apply_reset();
        for (int n = 0; n < 79; n++) step(1'b1, n == 0, n, n);
        total++; if (out_valid !== 1'b1 || out_eop !== 1'b0) begin bad++; $display("FAIL last_k62 got=%b%b want=10", out_valid, out_eop); end
        step(1'b1, 1'b1, 79, 79);
        total++; if (sync_err !== 1'b1 || out_eop !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL last_sop got err=%b eop=%b vld=%b want=1 0 0", sync_err, out_eop, out_valid); end
        step(1'b1, 1'b0, 80, 80);
        total++; if (sync_err !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL last_after got err=%b vld=%b want=0 0", sync_err, out_valid); end
    endtask

    task automatic test_back_to_back();
        logic signed [15:0] e_i;
        int m;
        int vlds;
        int sops;
        int eops;
        int errs;
        apply_reset();
        vlds = 0; sops = 0; eops = 0; errs = 0;
        for (int n = 0; n < 160; n++) begin
            step(1'b1, (n == 0) || (n == 80), n, -n);
            m = n % 80;
            total++; if (out_valid !== (m >= 16)) begin bad++; $display("FAIL b2b_valid n=%0d got=%b", n, out_valid); end
            if (m >= 16) begin
                e_i = ((m - 16) % 2 == 1) ? 16'(-n) : 16'(n);
                total++; if (out_i !== e_i || out_q !== -e_i) begin bad++; $display("FAIL b2b_data n=%0d got=%0d/%0d want=%0d/%0d", n, out_i, out_q, e_i, -e_i); end
            end
            if (out_valid === 1'b1) vlds++;
            if (out_sop === 1'b1) sops++;
            if (out_eop === 1'b1) eops++;
            if (sync_err === 1'b1) errs++;
        end
        total++; if (vlds != 128) begin bad++; $display("FAIL b2b_count got=%0d want=128", vlds); end
        total++; if (sops != 2 || eops != 2) begin bad++; $display("FAIL b2b_marks got=%0d/%0d want=2/2", sops, eops); end
        total++; if (errs != 0) begin bad++; $display("FAIL b2b_sync_err got=%0d want=0", errs); end
    endtask

    task automatic test_reset_mid();
        int vlds;
        apply_reset();
        for (int n = 0; n < 27; n++) step(1'b1, n == 0, n, n);
        total++; if (out_valid !== 1'b1 || out_i !== 16'sd26) begin bad++; $display("FAIL rstmid_pre got=%b %0d want=1 26", out_valid, out_i); end
        #2 rst = 1'b1;
        #2;
        total++; if ({out_valid, out_sop, out_eop, sync_err} !== 4'b0000 || out_i !== 16'sd0 || out_q !== 16'sd0) begin bad++; $display("FAIL rstmid_clear got=%b%b%b%b %0d/%0d want=0000 0/0", out_valid, out_sop, out_eop, sync_err, out_i, out_q); end
        #2 rst = 1'b0;
        vlds = 0;
        for (int n = 27; n < 100; n++) begin
            step(1'b1, 1'b0, n, n);
            if (out_valid !== 1'b0 || sync_err !== 1'b0) vlds++;
        end
        total++; if (vlds != 0) begin bad++; $display("FAIL rstmid_after got=%0d events want=0", vlds); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_stall();
        test_sync_err();
        test_sop_at_last();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cp_strip_derot.md
CP_STRIP_DEROT -- requirements
Module: cp_strip_derot

Interface
REQ-001 Parameter N_FFT, default 64, useful samples per OFDM symbol (power of 2, 8..1024).
REQ-002 Parameter CP_LEN, default 16, cyclic-prefix samples per symbol (1..N_FFT-1).
REQ-003 Parameter W, default 16, signed sample width.
REQ-004 Reset rst, asynchronous, active-high; clock clk.
REQ-005 clk  input  1  clock, all logic rising-edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 en  input  1  input sample valid; low = stall, no state change.
REQ-008 in_sop  input  1  first CP sample of a received symbol, qualified by en.
REQ-009 in_i, in_q  input  W  signed received I/Q samples.
REQ-010 out_i, out_q  output  W  signed de-rotated useful samples.
REQ-011 out_valid  output  1  out_i/out_q valid.
REQ-012 out_sop  output  1  first useful sample (FFT bin-order start).
REQ-013 out_eop  output  1  last (N_FFT-th) useful sample.
REQ-014 sync_err  output  1  one-cycle pulse: in_sop arrived mid-symbol.

Function
REQ-015 States IDLE, CP, DATA; a sample is accepted only when en=1.
REQ-016 IDLE: accepted sample with in_sop=1 is CP index 0 -> CP, cnt=1; accepted samples without in_sop are discarded.
REQ-017 CP: discard samples; on the accepted sample at cnt=CP_LEN-1 -> DATA, cnt=0 (CP_LEN=1 goes straight from IDLE to DATA).
REQ-018 DATA: forward each accepted sample, index k=cnt; at k=N_FFT-1 -> IDLE.
REQ-019 De-rotation: k even -> output = input; k odd -> output = saturating negation of input; k restarts at 0 every symbol.
REQ-020 Saturating negation: -(-2^(W-1)) = 2^(W-1)-1; all other values exact two's complement negation.
REQ-021 Latency: output registered, exactly 1 cycle from accepted input to out_valid.
REQ-022 out_sop=1 with out_valid at k=0, out_eop=1 with out_valid at k=N_FFT-1, both 0 otherwise.
REQ-023 out_valid=0 on every cycle whose input was not a forwarded DATA sample; out_i/out_q hold last value when out_valid=0.
REQ-024 en=0 in any state: cnt and state hold, out_valid=0, in_sop ignored.
REQ-025 Accepted in_sop while in CP or DATA: current symbol abandoned without out_eop, sync_err pulses 1 cycle (aligned with outputs, 1-cycle latency), restart as CP index 0, cnt=1.
REQ-026 Accepted in_sop on the same cycle as DATA k=N_FFT-1 is not possible by REQ-025 ordering: in_sop wins, sample treated as new CP index 0, sync_err=1, no out_eop.
REQ-027 Back-to-back symbols: in_sop on the first accepted sample after DATA end is handled as in IDLE, sync_err=0, no gap cycle required.
REQ-028 Counter width clog2(N_FFT); no wrap beyond N_FFT-1 or CP_LEN-1.

Reset
REQ-029 rst: state=IDLE, cnt=0, out_i=out_q=0, out_valid=out_sop=out_eop=sync_err=0.
REQ-030 rst asserted mid-symbol discards the symbol; first sample after deassertion is treated per IDLE.

Structure
REQ-031 Shared package ofdm_pkg holds state enum (IDLE, CP, DATA), default N_FFT=64, CP_LEN=16, W=16.
REQ-032 One sub-module sat_negate (W-bit combinational saturating negate), instanced twice (I, Q).

Verification
REQ-033 N_FFT=64, CP_LEN=16, continuous en, in_sop at sample 0, in_i=n (sample index) -> 64 outputs starting cycle 17 after sop: 16,-17,18,-19,...,78,-79; out_sop at first, out_eop at last.
REQ-034 Odd-index input in_i=-32768, in_q=32767 -> out_i=32767, out_q=-32767.
REQ-035 en toggled 1,0,1,0 throughout a symbol -> identical output sequence to REQ-033, out_valid only on cycles after en=1 DATA samples.
REQ-036 in_sop reasserted at DATA k=30 -> sync_err pulse, no out_eop, next symbol's first output after 16 more CP samples at k=0 un-negated.
REQ-037 Two symbols back-to-back (160 samples, sop at 0 and 80) -> 128 outputs, two sop/eop pairs, sync_err never asserted.
REQ-038 rst pulsed at DATA k=10 -> all outputs 0 next cycle; samples without in_sop afterwards produce no out_valid.
